// File: rtl/pipelined_divider_hs.sv
// -----------------------------------------------------------------------------
// pipelined_divider_hs
//
// Purpose:
//   Restoring integer divider that resolves one quotient bit per pipeline
//   stage. It uses a valid/ready handshake with a global stall. Signed
//   operands are optional, an opaque tag travels with each operation, and the
//   result carries divide-by-zero and overflow flags. An operation accepted at
//   edge k is presented on the outputs after edge k+DIVIDEND+1. The register
//   levels are:
//     - operand/magnitude capture;
//     - DIVIDEND restoring steps;
//     - sign/flag fix-up.
//
// Parameters:
//   DIVIDEND  dividend / quotient width (>= 2)
//   DIVISOR   divisor / remainder width (>= 2, <= DIVIDEND)
//   SIGNED    0 = unsigned operands, 1 = two's-complement operands
//   TAG_W     width of the opaque per-operation tag
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready = pipeline may advance)
//   dividend, divisor   operands
//   in_tag              tag returned unchanged with the result
//   out_valid/out_ready result handshake
//   quotient, remainder result
//   out_tag             tag of the presented result
//   div_by_zero         presented result had divisor == 0
//   overflow            presented result is signed most-negative / -1
// -----------------------------------------------------------------------------
module pipelined_divider_hs #(
  parameter int unsigned DIVIDEND = 8,
  parameter int unsigned DIVISOR  = 4,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned TAG_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder,
  output logic [TAG_W-1:0]    out_tag,
  output logic                div_by_zero,
  output logic                overflow
);

  // Stage 0 is the operand capture; stages 1..DIVIDEND are restoring steps.
  localparam int unsigned NS   = DIVIDEND + 1;
  localparam int unsigned LAST = NS - 1;

  localparam logic [DIVIDEND-1:0] MOST_NEG = {1'b1, {(DIVIDEND-1){1'b0}}};

  // Per-operation information carried alongside the arithmetic.
  typedef struct packed {
    logic               qneg;    // negate quotient at fix-up
    logic               rneg;    // negate remainder at fix-up
    logic               dz;      // divisor was zero
    logic               ovf;     // signed most-negative / -1
    logic [DIVISOR-1:0] raw_lo;  // raw dividend low bits for the /0 result
  } meta_t;

  // Pipeline stage state.
  logic               vld_q  [NS];
  logic               vld_d  [NS];
  logic [DIVISOR-1:0] rem_q  [NS];
  logic [DIVISOR-1:0] rem_d  [NS];
  logic [DIVIDEND-1:0] quo_q [NS];
  logic [DIVIDEND-1:0] quo_d [NS];
  logic [DIVISOR-1:0] dvs_q  [NS];
  logic [DIVISOR-1:0] dvs_d  [NS];
  logic [TAG_W-1:0]   tag_q  [NS];
  logic [TAG_W-1:0]   tag_d  [NS];
  meta_t              meta_q [NS];
  meta_t              meta_d [NS];

  // Restoring step temporaries, one per stage (index 0 unused).
  logic [DIVISOR:0]   part_w [NS];
  logic [DIVISOR:0]   diff_w [NS];
  logic               ge_w   [NS];

  // Output (fix-up) register.
  logic                out_vld_q, out_vld_d;
  logic [DIVIDEND-1:0] out_quo_q, out_quo_d;
  logic [DIVISOR-1:0]  out_rem_q, out_rem_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic                out_dz_q,  out_dz_d;
  logic                out_ovf_q, out_ovf_d;

  logic advance;
  logic dnd_neg;
  logic dvs_neg;

  // The whole pipeline moves as one; a held output stalls every stage.
  assign advance  = out_ready || !out_vld_q;
  assign in_ready = advance;

  always_comb begin
    // Stage 0: capture operands as magnitudes plus the sign/flag decisions.
    dnd_neg = (SIGNED != 0) && dividend[DIVIDEND-1];
    dvs_neg = (SIGNED != 0) && divisor[DIVISOR-1];

    vld_d[0]  = in_valid;
    rem_d[0]  = '0;
    quo_d[0]  = dnd_neg ? -dividend : dividend;
    dvs_d[0]  = dvs_neg ? -divisor : divisor;
    tag_d[0]  = in_tag;
    meta_d[0].qneg   = dnd_neg ^ dvs_neg;
    meta_d[0].rneg   = dnd_neg;
    meta_d[0].dz     = (divisor == '0);
    meta_d[0].ovf    = (SIGNED != 0) && (DIVISOR == DIVIDEND) &&
                       (dividend == MOST_NEG) && (divisor == '1);
    meta_d[0].raw_lo = dividend[DIVISOR-1:0];

    part_w[0] = '0;
    diff_w[0] = '0;
    ge_w[0]   = 1'b0;

    // Restoring steps: shift the next dividend bit into the partial
    // remainder, subtract when it fits, and shift the outcome into the
    // quotient from the bottom. The quotient register doubles as the
    // remaining-dividend shift register.
    for (int unsigned i = 1; i < NS; i++) begin
      part_w[i] = {rem_q[i-1], quo_q[i-1][DIVIDEND-1]};
      diff_w[i] = part_w[i] - {1'b0, dvs_q[i-1]};
      ge_w[i]   = (part_w[i] >= {1'b0, dvs_q[i-1]});

      vld_d[i]  = vld_q[i-1];
      rem_d[i]  = ge_w[i] ? diff_w[i][DIVISOR-1:0] : part_w[i][DIVISOR-1:0];
      quo_d[i]  = {quo_q[i-1][DIVIDEND-2:0], ge_w[i]};
      dvs_d[i]  = dvs_q[i-1];
      tag_d[i]  = tag_q[i-1];
      meta_d[i] = meta_q[i-1];
    end

    // Fix-up: restore signs, or substitute the fixed divide-by-zero result.
    // The most-negative / -1 case needs no special arithmetic: the magnitude
    // quotient already equals the wrapped most-negative value.
    out_vld_d = vld_q[LAST];
    out_tag_d = tag_q[LAST];
    out_dz_d  = meta_q[LAST].dz;
    out_ovf_d = meta_q[LAST].ovf;
    if (meta_q[LAST].dz) begin
      out_quo_d = '1;
      out_rem_d = meta_q[LAST].raw_lo;
    end else begin
      out_quo_d = meta_q[LAST].qneg ? -quo_q[LAST] : quo_q[LAST];
      out_rem_d = meta_q[LAST].rneg ? -rem_q[LAST] : rem_q[LAST];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NS; i++) begin
        vld_q[i]  <= 1'b0;
        rem_q[i]  <= '0;
        quo_q[i]  <= '0;
        dvs_q[i]  <= '0;
        tag_q[i]  <= '0;
        meta_q[i] <= '0;
      end
      out_vld_q <= 1'b0;
      out_quo_q <= '0;
      out_rem_q <= '0;
      out_tag_q <= '0;
      out_dz_q  <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned i = 0; i < NS; i++) begin
        vld_q[i]  <= vld_d[i];
        rem_q[i]  <= rem_d[i];
        quo_q[i]  <= quo_d[i];
        dvs_q[i]  <= dvs_d[i];
        tag_q[i]  <= tag_d[i];
        meta_q[i] <= meta_d[i];
      end
      out_vld_q <= out_vld_d;
      out_quo_q <= out_quo_d;
      out_rem_q <= out_rem_d;
      out_tag_q <= out_tag_d;
      out_dz_q  <= out_dz_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_valid   = out_vld_q;
  assign quotient    = out_quo_q;
  assign remainder   = out_rem_q;
  assign out_tag     = out_tag_q;
  assign div_by_zero = out_dz_q;
  assign overflow    = out_ovf_q;

endmodule

// File: tb/tb_pipelined_divider_hs.sv
// -----------------------------------------------------------------------------
// tb_pipelined_divider_hs
//
// Self-checking bench for pipelined_divider_hs. It has three instances:
//   A: 8/4 unsigned; covers directed operations, bubbles, back-pressure and
//      reset mid-flight.
//   B: 3/2 unsigned; every operand pair is issued back-to-back.
//   C: 4/4 signed; covers sign handling, overflow and divide-by-zero.
// -----------------------------------------------------------------------------
module tb_pipelined_divider_hs;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // Instance A: DIVIDEND=8, DIVISOR=4, unsigned
  logic       a_iv, a_ir, a_ov, a_or, a_dz, a_of;
  logic [7:0] a_dd, a_q;
  logic [3:0] a_dv, a_r, a_it, a_ot;

  // Instance B: DIVIDEND=3, DIVISOR=2, unsigned
  logic       b_iv, b_ir, b_ov, b_or, b_dz, b_of;
  logic [2:0] b_dd, b_q;
  logic [1:0] b_dv, b_r;
  logic [3:0] b_it, b_ot;

  // Instance C: DIVIDEND=4, DIVISOR=4, signed
  logic       c_iv, c_ir, c_ov, c_or, c_dz, c_of;
  logic [3:0] c_dd, c_q, c_dv, c_r, c_it, c_ot;

  pipelined_divider_hs #(.DIVIDEND(8), .DIVISOR(4), .SIGNED(0), .TAG_W(4)) u_a (
    .clock(clock), .reset(reset),
    .in_valid(a_iv), .in_ready(a_ir), .dividend(a_dd), .divisor(a_dv), .in_tag(a_it),
    .out_valid(a_ov), .out_ready(a_or), .quotient(a_q), .remainder(a_r), .out_tag(a_ot),
    .div_by_zero(a_dz), .overflow(a_of)
  );

  pipelined_divider_hs #(.DIVIDEND(3), .DIVISOR(2), .SIGNED(0), .TAG_W(4)) u_b (
    .clock(clock), .reset(reset),
    .in_valid(b_iv), .in_ready(b_ir), .dividend(b_dd), .divisor(b_dv), .in_tag(b_it),
    .out_valid(b_ov), .out_ready(b_or), .quotient(b_q), .remainder(b_r), .out_tag(b_ot),
    .div_by_zero(b_dz), .overflow(b_of)
  );

  pipelined_divider_hs #(.DIVIDEND(4), .DIVISOR(4), .SIGNED(1), .TAG_W(4)) u_c (
    .clock(clock), .reset(reset),
    .in_valid(c_iv), .in_ready(c_ir), .dividend(c_dd), .divisor(c_dv), .in_tag(c_it),
    .out_valid(c_ov), .out_ready(c_or), .quotient(c_q), .remainder(c_r), .out_tag(c_ot),
    .div_by_zero(c_dz), .overflow(c_of)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_a(input logic [7:0] dd, input logic [3:0] dv, input logic [3:0] tg,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz,
                       input string nm);
    int unsigned lat;
    a_dd = dd; a_dv = dv; a_it = tg; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    lat = 0;
    while (!a_ov && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, " lat"}, lat, 9);
    check({nm, " q"},   a_q, eq);
    check({nm, " r"},   a_r, er);
    check({nm, " tag"}, a_ot, tg);
    check({nm, " dz"},  a_dz, edz);
    check({nm, " ovf"}, a_of, 0);
    tick();
  endtask

  task automatic run_c(input logic [3:0] dd, input logic [3:0] dv, input logic [3:0] tg,
                       input logic [3:0] eq, input logic [3:0] er, input logic edz,
                       input logic eov, input string nm);
    int unsigned lat;
    check({nm, " in_ready"}, c_ir, 1);
    c_dd = dd; c_dv = dv; c_it = tg; c_iv = 1'b1;
    tick();
    c_iv = 1'b0;
    lat = 0;
    while (!c_ov && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, " lat"}, lat, 5);
    check({nm, " q"},   c_q, eq);
    check({nm, " r"},   c_r, er);
    check({nm, " tag"}, c_ot, tg);
    check({nm, " dz"},  c_dz, edz);
    check({nm, " ovf"}, c_of, eov);
    tick();
  endtask

  // Back-pressure vectors: divisor 5 throughout.
  logic [7:0] bp_dd [5] = '{8'd23, 8'd47, 8'd99, 8'd128, 8'd255};
  logic [7:0] bp_q  [5] = '{8'd4,  8'd9,  8'd19, 8'd25,  8'd51};
  logic [3:0] bp_r  [5] = '{4'd3,  4'd2,  4'd4,  4'd3,   4'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned w;
    int unsigned n;
    logic [9:0]  obs;
    logic        seen;
    int          first_c, last_c, nr;
    int          edd, edv, eq, er, edz;

    a_iv = 0; a_dd = '0; a_dv = '0; a_it = '0; a_or = 0;
    b_iv = 0; b_dd = '0; b_dv = '0; b_it = '0; b_or = 1;
    c_iv = 0; c_dd = '0; c_dv = '0; c_it = '0; c_or = 1;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst a out_valid", a_ov, 0);
    check("rst a quotient",  a_q, 0);
    check("rst a remainder", a_r, 0);
    check("rst a out_tag",   a_ot, 0);
    check("rst a dz",        a_dz, 0);
    check("rst a ovf",       a_of, 0);
    check("rst a in_ready",  a_ir, 1);
    check("rst b out_valid", b_ov, 0);
    check("rst c out_valid", c_ov, 0);
    a_or = 1'b1;

    // Directed unsigned operations
    run_a(8'd100, 4'd7,  4'd3,  8'd14,  4'd2, 1'b0, "u100/7");
    run_a(8'hB5,  4'd0,  4'd5,  8'hFF,  4'd5, 1'b1, "u181/0");
    run_a(8'd255, 4'd1,  4'hC,  8'd255, 4'd0, 1'b0, "u255/1");
    run_a(8'd7,   4'd15, 4'd1,  8'd0,   4'd7, 1'b0, "u7/15");
    run_a(8'd255, 4'd15, 4'd9,  8'd17,  4'd0, 1'b0, "u255/15");

    // Bubbles: in_valid 1,0,1 must come out as 1,0,1
    a_dd = 8'd200; a_dv = 4'd9; a_it = 4'd1; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    tick();
    a_dd = 8'd50; a_dv = 4'd3; a_it = 4'd2; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    obs = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      obs[c-1] = a_ov;
      if (c == 7) begin
        check("bub1 tag", a_ot, 1);
        check("bub1 q",   a_q, 22);
        check("bub1 r",   a_r, 2);
      end
      if (c == 9) begin
        check("bub2 tag", a_ot, 2);
        check("bub2 q",   a_q, 16);
        check("bub2 r",   a_r, 2);
      end
    end
    check("bubble pattern", obs, 10'h140);

    // Back-pressure: 5 back-to-back operations, 3-cycle stall on first result
    for (int i = 0; i < 5; i++) begin
      a_dd = bp_dd[i]; a_dv = 4'd5; a_it = 4'(6 + i); a_iv = 1'b1;
      tick();
    end
    a_iv = 1'b0;
    w = 0;
    while (!a_ov && w < 20) begin
      tick();
      w++;
    end
    check("bp first lat", w, 5);
    a_or = 1'b0;
    // This operation is offered only while stalled and must be dropped.
    a_dd = 8'h11; a_dv = 4'd1; a_it = 4'hF; a_iv = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp in_ready",   a_ir, 0);
      check("bp hold valid", a_ov, 1);
      check("bp hold tag",   a_ot, 6);
      check("bp hold q",     a_q, 4);
      check("bp hold r",     a_r, 3);
    end
    a_or = 1'b1;
    a_iv = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (a_ov) begin
        if (n < 5) begin
          check("bp tag", a_ot, 6 + n);
          check("bp q",   a_q, bp_q[n]);
          check("bp r",   a_r, bp_r[n]);
        end
        n++;
      end
      tick();
    end
    check("bp count", n, 5);

    // Reset with 4 operations in flight
    for (int i = 0; i < 4; i++) begin
      a_dd = 8'(i * 30 + 10); a_dv = 4'd3; a_it = 4'(i); a_iv = 1'b1;
      tick();
    end
    a_iv = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst mid in_ready",  a_ir, 1);
    check("rst mid out_valid", a_ov, 0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | a_ov;
    end
    check("rst mid drained", seen, 0);

    // Exhaustive 3/2 unsigned, back-to-back
    first_c = -1;
    last_c  = -1;
    nr      = 0;
    for (int c = 0; c < 45; c++) begin
      if (b_ov) begin
        if (nr < 32) begin
          edd = nr % 8;
          edv = nr / 8;
          if (edv == 0) begin
            eq = 7; er = edd % 4; edz = 1;
          end else begin
            eq = edd / edv; er = edd % edv; edz = 0;
          end
          check($sformatf("B q%0d", nr),   b_q, eq);
          check($sformatf("B r%0d", nr),   b_r, er);
          check($sformatf("B dz%0d", nr),  b_dz, edz);
          check($sformatf("B tag%0d", nr), b_ot, nr % 16);
          check($sformatf("B ovf%0d", nr), b_of, 0);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        nr++;
      end
      if (c < 32) begin
        b_iv = 1'b1; b_dd = 3'(c % 8); b_dv = 2'(c / 8); b_it = 4'(c % 16);
      end else begin
        b_iv = 1'b0;
      end
      tick();
    end
    check("B count",   nr, 32);
    check("B spacing", last_c - first_c, 31);
    check("B in_ready", b_ir, 1);

    // Signed 4/4
    run_c(4'h9, 4'h2, 4'd1, 4'hD, 4'hF, 1'b0, 1'b0, "s-7/2");
    run_c(4'h7, 4'hE, 4'd2, 4'hD, 4'h1, 1'b0, 1'b0, "s7/-2");
    run_c(4'h8, 4'hF, 4'd3, 4'h8, 4'h0, 1'b0, 1'b1, "s-8/-1");
    run_c(4'h8, 4'h1, 4'd4, 4'h8, 4'h0, 1'b0, 1'b0, "s-8/1");
    run_c(4'h8, 4'h0, 4'd5, 4'hF, 4'h8, 1'b1, 1'b0, "s-8/0");
    run_c(4'hA, 4'hC, 4'd6, 4'h1, 4'hE, 1'b0, 1'b0, "s-6/-4");
    run_c(4'h5, 4'h3, 4'd7, 4'h1, 4'h2, 1'b0, 1'b0, "s5/3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_divider_hs.md
Name: pipelined_divider_hs

Overview:
- Parametrised successor to the fixed-width pipelined divider: restoring division, one quotient bit resolved per pipeline stage.
- Adds:
  - valid/ready handshake with global stall;
  - optional signed mode;
  - per-operation tag passthrough;
  - divide-by-zero and overflow flags;
  - synchronous reset.
- Sits between the issuing datapath and the result writeback.
- Accepts one operation per cycle when not stalled.

Parameters:
- DIVIDEND, 8, dividend and quotient width in bits (>=2).
- DIVISOR, 4, divisor and remainder width in bits (>=2, <=DIVIDEND).
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands.
- TAG_W, 4, width of the opaque tag carried with each operation.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented this cycle.
- in_ready  output  1  divider can accept an operation this cycle.
- dividend  input  DIVIDEND  numerator.
- divisor  input  DIVISOR  denominator.
- in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  output  1  result present on the output ports.
- out_ready  input  1  consumer accepts the result this cycle.
- quotient  output  DIVIDEND  quotient.
- remainder  output  DIVISOR  remainder.
- out_tag  output  TAG_W  tag of the operation whose result is presented.
- div_by_zero  output  1  the presented result had divisor == 0.
- overflow  output  1  the presented result is a signed most-negative / -1 operation.

Behaviour:
- Reset:
  - Clears every stage valid bit; out_valid = 0.
  - quotient, remainder, out_tag, div_by_zero and overflow all read 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations; nothing emerges afterwards.
- Pipeline:
  - DIVIDEND stages plus one sign/flag fix-up stage, so latency is DIVIDEND+1 cycles.
  - An operation accepted at edge k has out_valid high after edge k+DIVIDEND+1, absent stalls.
- Handshake:
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - advance = out_ready || !out_valid. When advance = 1, every stage shifts one place.
  - When advance = 0, all stages hold and the output holds stable.
  - in_ready = advance, derived combinationally from out_ready and out_valid.
  - in_valid while in_ready = 0 is ignored. The source must hold the operands.
  - Bubbles: stage valid bits propagate, so a gap in in_valid produces a gap in out_valid.
  - Throughput is 1 operation per cycle while out_ready = 1.
- Unsigned arithmetic (SIGNED = 0):
  - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.
  - Partial remainder is DIVISOR+1 bits wide internally to hold the borrow.
- Signed arithmetic (SIGNED = 1):
  - Operands are converted to magnitudes in stage 0.
  - Quotient truncates toward zero. Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - The most-negative dividend magnitude needs no extra bit: the unsigned datapath handles it.
- Divide by zero:
  - div_by_zero = 1, quotient = all ones, remainder = dividend[DIVISOR-1:0].
  - Applies in both modes.
  - The operation still occupies its pipeline slot and is delivered at normal latency.
- Overflow:
  - Set only when SIGNED = 1 and DIVISOR == DIVIDEND, with dividend = most negative and divisor = -1.
  - Result: quotient = most negative (wraps), remainder = 0, overflow = 1.
  - With SIGNED = 0, or DIVISOR < DIVIDEND, overflow is tied to 0.
- Flags and tag are valid only while out_valid = 1. Their values are don't-care otherwise.
- Simultaneous accept and output transfer in the same cycle is legal and is the steady state.

Test Plan:
- Unsigned, DIVIDEND=8, DIVISOR=4: dividend 100, divisor 7, tag 3 -> after 9 cycles: quotient 14, remainder 2, out_tag 3, both flags 0.
- Exhaustive unsigned, DIVIDEND=3, DIVISOR=2: all 32 {divisor,dividend} pairs issued back-to-back with out_ready = 1 -> results in order, one per cycle; divisor-0 cases give quotient 7, remainder = dividend[1:0], div_by_zero = 1.
- Signed, DIVIDEND=DIVISOR=4:
  - -7 / 2 -> quotient -3 (4'hD), remainder -1 (4'hF).
  - 7 / -2 -> quotient -3 (4'hD), remainder 1.
  - -8 / -1 -> quotient 4'h8, remainder 0, overflow 1.
- Back-pressure:
  - Issue 5 operations; hold out_ready = 0 for 3 cycles after the first result appears.
  - Required: in_ready low, output stable, no loss or duplication, all 5 tags emerge in order.
- Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 at the same relative spacing.
- Reset mid-flight: assert reset for 1 cycle with 4 operations in flight -> out_valid stays 0 for the next DIVIDEND+2 cycles, and in_ready = 1 in the cycle after reset deasserts.
